// File: rtl/bus_gen_pkg.sv
// Shared types for the generic bus arbiter: arbitration policy and FSM state encodings.
package bus_gen_pkg;

   typedef enum logic [0:0] {
      ARB_RR    = 1'b0,
      ARB_FIXED = 1'b1
   } arb_mode_e;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      DELIVER = 2'd2
   } arb_state_e;

   localparam int DROP_W = 16;
   localparam logic [DROP_W-1:0] DROP_MAX = 16'hFFFF;

   // Saturating increment used by the drop counter.
   function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] val);
      logic [DROP_W-1:0] res;
      if (val != DROP_MAX) begin
         res = val + 16'd1;
      end else begin
         res = val;
      end
      return res;
   endfunction

endpackage

// File: rtl/bus_arbiter_gen_if.sv
// Device-side bus bundle: source FIFO flags/heads in, pop/push strobes and delivery data out.
interface bus_arbiter_gen_if #(
   parameter int DRVRS   = 5,
   parameter int PCKG_SZ = 16
);
   logic [DRVRS-1:0]         pndng;
   logic [DRVRS*PCKG_SZ-1:0] D_pop;
   logic [DRVRS-1:0]         pop;
   logic [DRVRS-1:0]         push;
   logic [DRVRS*PCKG_SZ-1:0] D_push;
   logic                     busy;
   logic [15:0]              drop_cnt;

   modport master (
      input  pndng,
      input  D_pop,
      output pop,
      output push,
      output D_push,
      output busy,
      output drop_cnt
   );

   modport slave (
      output pndng,
      output D_pop,
      input  pop,
      input  push,
      input  D_push,
      input  busy,
      input  drop_cnt
   );
endinterface

// File: rtl/bus_rr_picker.sv
// Combinational rotating-priority picker: first request found after ptr_i, wrapping at N-1.
module bus_rr_picker #(
   parameter int N     = 5,
   parameter int IDX_W = 3
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N-1:0]     gnt_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             valid_o
);

   int cand;

   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      cand    = 0;
      for (int k = 1; k <= N; k++) begin
         cand = (int'(ptr_i) + k) % N;
         if (!valid_o && req_i[cand[IDX_W-1:0]]) begin
            valid_o = 1'b1;
            idx_o   = cand[IDX_W-1:0];
            gnt_o   = N'(1'b1) << cand;
         end else begin
            valid_o = valid_o;
         end
      end
   end

endmodule

// File: rtl/bus_arbiter_gen.sv
// Packet arbiter: grants one source at a time, pops its FIFO head and delivers it
// to one destination, to all others (broadcast), or counts it as dropped.
module bus_arbiter_gen
   import bus_gen_pkg::*;
#(
   parameter int                DRVRS     = 5,
   parameter int                PCKG_SZ   = 16,
   parameter int                ADDR_W    = 8,
   parameter logic [ADDR_W-1:0] BROADCAST = 8'b1000_1111,
   parameter arb_mode_e         ARB_MODE  = ARB_RR
) (
   input logic               clk,
   input logic               reset,
   bus_arbiter_gen_if.master bus
);

   localparam int IDX_W = $clog2(DRVRS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DRVRS - 1);

   arb_state_e          state_q, state_d;
   logic [IDX_W-1:0]    winner_q, winner_d;
   logic [IDX_W-1:0]    last_grant_q, last_grant_d;
   logic [PCKG_SZ-1:0]  pkt_q, pkt_d;
   logic [DRVRS-1:0]    pop_q, pop_d;
   logic [DRVRS-1:0]    push_q, push_d;
   logic                busy_q, busy_d;
   logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;

   logic [PCKG_SZ-1:0]  dpop_s [DRVRS];
   logic [PCKG_SZ-1:0]  head_s;
   logic [ADDR_W-1:0]   dest_s;
   logic [DRVRS-1:0]    win_oh_s;
   logic [IDX_W-1:0]    ptr_s;
   logic [DRVRS-1:0]    pick_gnt_s;
   logic [IDX_W-1:0]    pick_idx_s;
   logic                pick_valid_s;

   for (genvar g = 0; g < DRVRS; g++) begin : g_slice
      assign dpop_s[g] = bus.D_pop[g*PCKG_SZ +: PCKG_SZ];
      assign bus.D_push[g*PCKG_SZ +: PCKG_SZ] = pkt_q;
   end

   assign head_s   = dpop_s[winner_q];
   assign dest_s   = head_s[PCKG_SZ-1 -: ADDR_W];
   assign win_oh_s = DRVRS'(1'b1) << winner_q;
   // Fixed priority reuses the rotating picker with the pointer parked on the last index.
   assign ptr_s    = (ARB_MODE == ARB_FIXED) ? LAST_IDX : last_grant_q;

   bus_rr_picker #(
      .N     (DRVRS),
      .IDX_W (IDX_W)
   ) u_picker (
      .req_i   (bus.pndng),
      .ptr_i   (ptr_s),
      .gnt_o   (pick_gnt_s),
      .idx_o   (pick_idx_s),
      .valid_o (pick_valid_s)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = IDLE;
      case (state_q)
         IDLE: begin
            if (pick_valid_s) begin
               state_d = GRANT;
            end else begin
               state_d = IDLE;
            end
         end
         GRANT:   state_d = DELIVER;
         DELIVER: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output decode: next values of the registered strobes, packet and counters.
   always_comb begin
      winner_d     = winner_q;
      last_grant_d = last_grant_q;
      pkt_d        = pkt_q;
      pop_d        = '0;
      push_d       = '0;
      drop_cnt_d   = drop_cnt_q;
      busy_d       = (state_d != IDLE);
      case (state_q)
         IDLE: begin
            if (pick_valid_s) begin
               winner_d     = pick_idx_s;
               last_grant_d = pick_idx_s;
               pop_d        = pick_gnt_s;
            end else begin
               pop_d = '0;
            end
         end
         GRANT: begin
            pkt_d = head_s;
            if (dest_s == BROADCAST) begin
               push_d = ~win_oh_s;
            end else if (int'(dest_s) < DRVRS) begin
               push_d = DRVRS'(1'b1) << dest_s;
            end else begin
               drop_cnt_d = sat_inc(drop_cnt_q);
            end
         end
         DELIVER: begin
            push_d = '0;
         end
         default: begin
            push_d = '0;
         end
      endcase
   end

   // Registered outputs and datapath state.
   always_ff @(posedge clk) begin
      if (reset) begin
         winner_q     <= '0;
         last_grant_q <= LAST_IDX;
         pkt_q        <= '0;
         pop_q        <= '0;
         push_q       <= '0;
         busy_q       <= 1'b0;
         drop_cnt_q   <= '0;
      end else begin
         winner_q     <= winner_d;
         last_grant_q <= last_grant_d;
         pkt_q        <= pkt_d;
         pop_q        <= pop_d;
         push_q       <= push_d;
         busy_q       <= busy_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

   assign bus.pop      = pop_q;
   assign bus.push     = push_q;
   assign bus.busy     = busy_q;
   assign bus.drop_cnt = drop_cnt_q;

endmodule
